// File: rtl/microseq_pkg.sv
// microseq_pkg: shared widths, selector codes, opcode/funct constants and state map
package microseq_pkg;
  localparam int STATE_W = 7;
  typedef logic [STATE_W-1:0] state_t;
  typedef enum logic [2:0] {
    N_ENC   = 3'b000,
    N_FETCH = 3'b001,
    N_JUMP  = 3'b010,
    N_CJMP  = 3'b011,
    N_CENC  = 3'b100,
    N_INC   = 3'b101,
    N_WAIT  = 3'b110,
    N_RESET = 3'b111
  } n_sel_t;
  typedef enum logic [1:0] {
    S_MOC  = 2'b00,
    S_COND = 2'b01,
    S_ZERO = 2'b10,
    S_ONE  = 2'b11
  } s_sel_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam state_t ST_ADD  = 7'd10;
  localparam state_t ST_SUB  = 7'd11;
  localparam state_t ST_AND  = 7'd12;
  localparam state_t ST_ADDI = 7'd14;
  localparam state_t ST_LW   = 7'd20;
  localparam state_t ST_SW   = 7'd24;
  localparam state_t ST_BEQ  = 7'd30;
  localparam state_t ST_J    = 7'd34;
  localparam state_t RESET_ST = 7'd0;
  localparam state_t FETCH_ST = 7'd1;
  localparam state_t TRAP_ST  = 7'd126;
endpackage

// File: rtl/opcode_state_encoder.sv
// opcode_state_encoder: maps opcode/funct to a microroutine entry state; hit=0 on a miss
module opcode_state_encoder
  import microseq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     state,
  output logic       hit
);
  always_comb begin
    state = FETCH_ST;
    hit   = 1'b1;
    case (opcode)
      OP_RTYPE: state = funct == FN_ADD ? ST_ADD :
                        funct == FN_SUB ? ST_SUB :
                        funct == FN_AND ? ST_AND : FETCH_ST;
      OP_LW:    state = ST_LW;
      OP_SW:    state = ST_SW;
      OP_BEQ:   state = ST_BEQ;
      OP_ADDI:  state = ST_ADDI;
      OP_J:     state = ST_J;
      default:  hit = 1'b0;
    endcase
    if (opcode == OP_RTYPE && funct != FN_ADD && funct != FN_SUB && funct != FN_AND) hit = 1'b0;
  end
endmodule

// File: rtl/microprogram_sequencer.sv
// microprogram_sequencer: next-microstate logic and state/incrementer registers.
// MSEQ_ILLEGAL_TRAP_EN routes encoder misses to TRAP_STATE and pulses illegal_op.
module microprogram_sequencer
  import microseq_pkg::*;
#(
  parameter int                 STATE_W     = microseq_pkg::STATE_W,
  parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(RESET_ST),
  parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(FETCH_ST),
  parameter logic [STATE_W-1:0] TRAP_STATE  = STATE_W'(TRAP_ST)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         N,
  input  logic [1:0]         S,
  input  logic               Inv,
  input  logic               IncRld,
  input  logic [STATE_W-1:0] CR,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               MOC,
  input  logic               cond,
  input  logic               zero,
  output logic [STATE_W-1:0] curState,
  output logic               illegal_op
);
  logic [STATE_W-1:0] cur_q, cur_d, inc_q, inc_d, enc_nxt;
  state_t             enc_state;
  logic               hit, c;

  opcode_state_encoder u_enc (
    .opcode (opcode),
    .funct  (funct),
    .state  (enc_state),
    .hit    (hit)
  );

  assign c = (S == S_MOC  ? MOC  :
              S == S_COND ? cond :
              S == S_ZERO ? zero : 1'b1) ^ Inv;
`ifdef MSEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign enc_nxt    = hit ? STATE_W'(enc_state) : TRAP_STATE;
  // pulse only when the trap is first entered, not while re-trapping from it
  assign illegal_d  = !hit && (N == N_ENC || (N == N_CENC && !c)) && cur_q != TRAP_STATE;
  assign illegal_op = illegal_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) illegal_q <= 1'b0;
    else illegal_q <= illegal_d;
`else
  assign enc_nxt    = hit ? STATE_W'(enc_state) : FETCH_STATE;
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    cur_d = cur_q;
    case (N)
      N_ENC:   cur_d = enc_nxt;
      N_FETCH: cur_d = FETCH_STATE;
      N_JUMP:  cur_d = CR;
      N_CJMP:  cur_d = c ? CR : inc_q;
      N_CENC:  cur_d = c ? CR : enc_nxt;
      N_INC:   cur_d = inc_q;
      N_WAIT:  cur_d = c ? inc_q : cur_q;
      default: cur_d = RESET_STATE;
    endcase
    inc_d = IncRld ? cur_d + 1'b1 : inc_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur_q <= RESET_STATE;
      inc_q <= RESET_STATE + 1'b1;
    end else begin
      cur_q <= cur_d;
      inc_q <= inc_d;
    end

  assign curState = cur_q;
endmodule

// File: doc/microprogram_sequencer.md
Name: microprogram_sequencer

Overview:
- Upstream neighbour of the control register. Computes the next microstate and holds it in the state register `curState`.
- `curState` addresses the microstore ROM. The ROM's 45-bit word is then latched on negedge by the control register.
- The control register's fields N, S, Inv, CR and IncRld are fed back here. This closes the microprogram loop.
- All state updates occur on posedge `clk`, so control fields are stable half a cycle before use.

Parameters:
- STATE_W, 7, width of microstate address.
- RESET_STATE, 7'd0, state entered on reset and on N=111.
- FETCH_STATE, 7'd1, fixed fetch entry state (N=001).
- TRAP_STATE, 7'd126, illegal-instruction state (used only with optional feature).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- N  in  3  next-state selector from control register.
- S  in  2  condition selector.
- Inv  in  1  invert selected condition.
- IncRld  in  1  load enable for incrementer register.
- CR  in  7  jump target microstate.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- MOC  in  1  memory operation complete.
- cond  in  1  branch-condition result from the condition tester.
- zero  in  1  ALU zero flag.
- curState  out  7  current microstate, which is the ROM address.
- illegal_op  out  1  one-cycle pulse on an encoder miss.

Behaviour:
- Reset (async, reset_n=0):
  - curState=RESET_STATE; incReg=RESET_STATE+1; illegal_op=0.
  - Takes effect immediately, mid-operation included. The first posedge after release evaluates N normally.
- Condition select:
  - Selected condition c = sel(S)^Inv.
  - S=00 MOC, 01 cond, 10 zero, 11 constant 1.
- Next state, combinational, one-cycle latency to curState:
  - 000: encoder output.
  - 001: FETCH_STATE.
  - 010: CR (unconditional jump).
  - 011: c ? CR : incReg.
  - 100: c ? CR : encoder.
  - 101: incReg.
  - 110: c ? incReg : curState. Wait-hold: with S=00, Inv=0, remain until MOC.
  - 111: RESET_STATE.
- Register updates at posedge:
  - curState <= next.
  - If IncRld=1: incReg <= next+1, modulo 2^STATE_W, so 127 wraps to 0.
  - If IncRld=0: incReg holds.
- Encoder (combinational, from package table):
  - opcode 000000 with funct 100000 (ADD) -> 10; funct 100010 (SUB) -> 11; funct 100100 (AND) -> 12.
  - opcode 100011 (LW) -> 20; 101011 (SW) -> 24; 000100 (BEQ) -> 30; 001000 (ADDI) -> 14; 000010 (J) -> 34.
  - Any other combination is a miss.
- Encoder miss (macro off): encoder yields FETCH_STATE. illegal_op is tied 0.
- Hold with IncRld=1: incReg reloads curState+1, so the value is unchanged.
- X/unknown N is not handled specially.

Optional Feature:
- Macro MSEQ_ILLEGAL_TRAP_EN.
- When defined:
  - An encoder miss selected by N=000, or by N=100 with c=0, makes next=TRAP_STATE.
  - illegal_op is registered high for exactly the cycle curState==TRAP_STATE is first entered.
- When undefined: a miss yields FETCH_STATE and illegal_op is constant 0.

Decomposition:
- Shared package `microseq_pkg` contains:
  - STATE_W.
  - The N selector codes as named constants.
  - The S codes.
  - The opcode/funct constants.
  - The encoder mapping state constants.
  - RESET/FETCH/TRAP state constants.
- One sub-module, `opcode_state_encoder`: opcode and funct in, 7-bit state plus a `hit` flag out.

Test Plan:
1. Reset: assert reset_n=0 mid-cycle -> curState=0 immediately; after release, N=001 -> curState=1 next posedge.
2. Increment chain: curState=1, N=101, IncRld=1 for 3 cycles -> 2,3,4. With IncRld=0 at state 4, N=101 -> curState=5 twice, since incReg is stuck at 5.
3. Wait-hold: curState=20, N=110, S=00, Inv=0, MOC=0 for 3 cycles -> stays 20; MOC=1 -> 21.
4. Conditional branch: N=011, S=10, CR=40. zero=1, Inv=0 -> 40; zero=1, Inv=1 -> incReg.
5. Decode: N=000 with opcode 100011 -> 20; with opcode 000000/funct 100010 -> 11; with opcode 111111 -> 1 (macro off) or 126 with a single illegal_op pulse (macro on).
6. Wrap: CR=127, N=010, IncRld=1, then N=101 -> curState=127 then 0.
